// File: rtl/reg_scoreboard_pkg.sv
// reg_scoreboard_pkg
// Shared register-index definitions for the scoreboard, register file and
// decode. Holds the architectural register count, index width, the
// hardwired zero register index and the default counter width.
package reg_scoreboard_pkg;

   localparam int NREGS     = 32;
   localparam int REG_IDX_W = 5;
   localparam int ZERO_IDX  = 31;
   localparam int CNT_W     = 2;

   typedef logic [REG_IDX_W-1:0] reg_idx_t;

endpackage

// File: rtl/reg_scoreboard_sat_counter.sv
// sb_sat_counter
// Outstanding-write counter for one architectural register.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   inc          : one more write to this register issued
//   dec          : one write to this register retired
//   clr          : flush; wins over inc/dec
//   cnt          : current count
//   nonzero      : registered (cnt != 0), loaded from the next-state count
//   max          : count is at its saturation value
// The caller never raises inc at max or dec at zero (unless inc is also set),
// so no wrap protection is needed here.
module sb_sat_counter #(
   parameter int CNT_W = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             inc,
   input  logic             dec,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt,
   output logic             nonzero,
   output logic             max
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             nz_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clr)             cnt_d = '0;
      else if (inc && !dec) cnt_d = cnt_q + CNT_W'(1);
      else if (dec && !inc) cnt_d = cnt_q - CNT_W'(1);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
         nz_q  <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         nz_q  <= |cnt_d;
      end
   end

   assign cnt     = cnt_q;
   assign nonzero = nz_q;
   assign max     = &cnt_q;

endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard
// Pending-write tracker in decode. Counts outstanding writes per
// architectural register, flags RAW hazards on the A/B read selects and
// stalls issue on a pending operand or a saturated destination counter.
// Register ZERO_IDX is never tracked.
// Ports:
//   clk, reset_n             : clock, asynchronous active-low reset
//   issue_valid/ready        : decode handshake (ready = !stall)
//   issue_wen/dsel/asel/bsel : destination and operand selects
//   wb_valid, wb_dsel        : writeback retire
//   flush                    : discard all outstanding writes
//   hazard_a/b, stall        : combinational hazard outputs
//   busy_mask                : registered per-register busy bits
//   err                      : sticky retire-with-nothing-pending error
// Build option: REG_SCOREBOARD_WB_BYPASS_EN suppresses a read hazard when
// the last pending write to that register retires in the same cycle.
module reg_scoreboard
   import reg_scoreboard_pkg::*;
#(
   parameter int NREGS    = reg_scoreboard_pkg::NREGS,
   parameter int CNT_W    = reg_scoreboard_pkg::CNT_W,
   parameter int ZERO_IDX = reg_scoreboard_pkg::ZERO_IDX
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     issue_valid,
   output logic                     issue_ready,
   input  logic                     issue_wen,
   input  logic [$clog2(NREGS)-1:0] issue_dsel,
   input  logic [$clog2(NREGS)-1:0] issue_asel,
   input  logic [$clog2(NREGS)-1:0] issue_bsel,
   input  logic                     wb_valid,
   input  logic [$clog2(NREGS)-1:0] wb_dsel,
   input  logic                     flush,
   output logic                     hazard_a,
   output logic                     hazard_b,
   output logic                     stall,
   output logic [NREGS-1:0]         busy_mask,
   output logic                     err
);

   localparam int                IDX_W = $clog2(NREGS);
   localparam logic [IDX_W-1:0]  ZIDX  = IDX_W'(ZERO_IDX);

   logic [NREGS-1:0][CNT_W-1:0] cnt;
   logic [NREGS-1:0]            nz, mx, inc, dec;
   logic                        fire, fire_wr, sat_dest;
   logic                        hz_a_raw, hz_b_raw, err_set;
   logic                        err_q;

   assign hz_a_raw = (issue_asel != ZIDX) && (|cnt[issue_asel]);
   assign hz_b_raw = (issue_bsel != ZIDX) && (|cnt[issue_bsel]);

`ifdef REG_SCOREBOARD_WB_BYPASS_EN
   // Register file forwards the retiring value, so the last pending write
   // retiring this cycle no longer blocks the read.
   assign hazard_a = hz_a_raw && !(wb_valid && wb_dsel == issue_asel &&
                                   cnt[issue_asel] == CNT_W'(1));
   assign hazard_b = hz_b_raw && !(wb_valid && wb_dsel == issue_bsel &&
                                   cnt[issue_bsel] == CNT_W'(1));
`else
   assign hazard_a = hz_a_raw;
   assign hazard_b = hz_b_raw;
`endif

   assign sat_dest    = issue_wen && (issue_dsel != ZIDX) && mx[issue_dsel];
   assign stall       = issue_valid && (hazard_a || hazard_b || sat_dest);
   assign issue_ready = !stall;
   assign fire        = issue_valid && issue_ready && !flush;
   assign fire_wr     = fire && issue_wen && (issue_dsel != ZIDX);

   // A retire to an idle register is an error, unless an issue to the same
   // register fires this cycle (retire ordered after issue) or flush drops it.
   // Retires of the zero register are ignored entirely.
   assign err_set = wb_valid && !flush && (wb_dsel != ZIDX) &&
                    (cnt[wb_dsel] == '0) && !(fire_wr && issue_dsel == wb_dsel);

   for (genvar r = 0; r < NREGS; r++) begin : g_cnt
      // Decrement only a nonzero counter; with an issue to an idle register
      // in the same cycle this leaves the count at 1.
      assign inc[r] = fire_wr && (issue_dsel == IDX_W'(r));
      assign dec[r] = wb_valid && (wb_dsel == IDX_W'(r)) && (r != ZERO_IDX) &&
                      (|cnt[r]);

      sb_sat_counter #(.CNT_W(CNT_W)) u_cnt (
         .clk     (clk),
         .reset_n (reset_n),
         .inc     (inc[r]),
         .dec     (dec[r]),
         .clr     (flush),
         .cnt     (cnt[r]),
         .nonzero (nz[r]),
         .max     (mx[r])
      );
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) err_q <= 1'b0;
      else if (err_set) err_q <= 1'b1;
   end

   assign busy_mask = nz;
   assign err       = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
module tb_reg_scoreboard;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        issue_valid, issue_ready, issue_wen;
   logic [4:0]  issue_dsel, issue_asel, issue_bsel;
   logic        wb_valid;
   logic [4:0]  wb_dsel;
   logic        flush;
   logic        hazard_a, hazard_b, stall;
   logic [31:0] busy_mask;
   logic        err;

   int total  = 0;
   int passed = 0;

`ifdef REG_SCOREBOARD_WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   always #5 clk = ~clk;

   reg_scoreboard dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .issue_valid (issue_valid),
      .issue_ready (issue_ready),
      .issue_wen   (issue_wen),
      .issue_dsel  (issue_dsel),
      .issue_asel  (issue_asel),
      .issue_bsel  (issue_bsel),
      .wb_valid    (wb_valid),
      .wb_dsel     (wb_dsel),
      .flush       (flush),
      .hazard_a    (hazard_a),
      .hazard_b    (hazard_b),
      .stall       (stall),
      .busy_mask   (busy_mask),
      .err         (err)
   );

   task automatic idle();
      issue_valid = 0; issue_wen = 0; issue_dsel = 0; issue_asel = 0;
      issue_bsel = 0; wb_valid = 0; wb_dsel = 0; flush = 0;
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      reset_n = 0; idle();
      issue_valid = 1; issue_asel = 5'd3;
      #12;
      total++; if (busy_mask !== 32'h0) $display("FAIL rst_busy: got %h want 0", busy_mask); else passed++;
      total++; if (err !== 1'b0) $display("FAIL rst_err: got %b want 0", err); else passed++;
      total++; if (stall !== 1'b0) $display("FAIL rst_stall: got %b want 0", stall); else passed++;
      total++; if (issue_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", issue_ready); else passed++;
      @(negedge clk); reset_n = 1; idle();
      tick();
   endtask

   task automatic test_raw();
      idle(); issue_valid = 1; issue_wen = 1; issue_dsel = 5'd5; #1;
      total++; if (stall !== 1'b0) $display("FAIL raw_issue_stall: got %b want 0", stall); else passed++;
      tick();
      issue_wen = 0; issue_asel = 5'd5; issue_bsel = 5'd5; #1;
      total++; if (hazard_a !== 1'b1) $display("FAIL raw_hz_a: got %b want 1", hazard_a); else passed++;
      total++; if (hazard_b !== 1'b1) $display("FAIL raw_hz_b: got %b want 1", hazard_b); else passed++;
      total++; if (stall !== 1'b1) $display("FAIL raw_stall: got %b want 1", stall); else passed++;
      total++; if (busy_mask !== 32'h20) $display("FAIL raw_busy: got %h want 00000020", busy_mask); else passed++;
      tick();
      wb_valid = 1; wb_dsel = 5'd5; #1;
      total++; if (hazard_a !== !BYP) $display("FAIL raw_wb_hz_a: got %b want %b", hazard_a, !BYP); else passed++;
      total++; if (stall !== !BYP) $display("FAIL raw_wb_stall: got %b want %b", stall, !BYP); else passed++;
      tick();
      wb_valid = 0; #1;
      total++; if (hazard_a !== 1'b0) $display("FAIL raw_after_hz_a: got %b want 0", hazard_a); else passed++;
      total++; if (stall !== 1'b0) $display("FAIL raw_after_stall: got %b want 0", stall); else passed++;
      total++; if (busy_mask !== 32'h0) $display("FAIL raw_after_busy: got %h want 0", busy_mask); else passed++;
      idle(); tick();
   endtask

   task automatic test_zero();
      idle(); issue_valid = 1; issue_wen = 1; issue_dsel = 5'd31;
      for (int i = 0; i < 3; i++) begin
         #1;
         total++; if (stall !== 1'b0) $display("FAIL zero_issue_stall%0d: got %b want 0", i, stall); else passed++;
         tick();
      end
      issue_wen = 0; issue_asel = 5'd31; issue_bsel = 5'd31; #1;
      total++; if (hazard_a !== 1'b0) $display("FAIL zero_hz_a: got %b want 0", hazard_a); else passed++;
      total++; if (hazard_b !== 1'b0) $display("FAIL zero_hz_b: got %b want 0", hazard_b); else passed++;
      total++; if (stall !== 1'b0) $display("FAIL zero_stall: got %b want 0", stall); else passed++;
      total++; if (busy_mask !== 32'h0) $display("FAIL zero_busy: got %h want 0", busy_mask); else passed++;
      idle(); tick();
   endtask

   task automatic test_sat();
      idle(); issue_valid = 1; issue_wen = 1; issue_dsel = 5'd7;
      repeat (3) tick();
      #1;
      total++; if (busy_mask !== 32'h80) $display("FAIL sat_busy: got %h want 00000080", busy_mask); else passed++;
      total++; if (stall !== 1'b1) $display("FAIL sat_stall: got %b want 1", stall); else passed++;
      total++; if (issue_ready !== 1'b0) $display("FAIL sat_ready: got %b want 0", issue_ready); else passed++;
      tick(); #1;
      total++; if (stall !== 1'b1) $display("FAIL sat_stall_hold: got %b want 1", stall); else passed++;
      wb_valid = 1; wb_dsel = 5'd7; #1;
      total++; if (stall !== 1'b1) $display("FAIL sat_stall_wb: got %b want 1", stall); else passed++;
      tick();
      wb_valid = 0; #1;
      total++; if (stall !== 1'b0) $display("FAIL sat_release: got %b want 0", stall); else passed++;
      tick();
      // counter is back at 3: three retires drain it
      issue_valid = 0; issue_wen = 0; wb_valid = 1; wb_dsel = 5'd7;
      repeat (3) tick();
      idle(); #1;
      total++; if (busy_mask !== 32'h0) $display("FAIL sat_drain_busy: got %h want 0", busy_mask); else passed++;
      total++; if (err !== 1'b0) $display("FAIL sat_drain_err: got %b want 0", err); else passed++;
      tick();
   endtask

   task automatic test_simul();
      idle(); issue_valid = 1; issue_wen = 1; issue_dsel = 5'd9;
      tick();
      wb_valid = 1; wb_dsel = 5'd9; #1;
      total++; if (stall !== 1'b0) $display("FAIL sim_stall: got %b want 0", stall); else passed++;
      tick();
      idle(); #1;
      total++; if (busy_mask !== 32'h200) $display("FAIL sim_busy: got %h want 00000200", busy_mask); else passed++;
      wb_valid = 1; wb_dsel = 5'd9;
      tick();
      idle(); #1;
      total++; if (busy_mask !== 32'h0) $display("FAIL sim_one_left: got %h want 0", busy_mask); else passed++;
      total++; if (err !== 1'b0) $display("FAIL sim_err: got %b want 0", err); else passed++;
      // idle register: issue and retire together leave one pending write
      issue_valid = 1; issue_wen = 1; issue_dsel = 5'd9; wb_valid = 1; wb_dsel = 5'd9;
      tick();
      idle(); #1;
      total++; if (busy_mask !== 32'h200) $display("FAIL sim0_busy: got %h want 00000200", busy_mask); else passed++;
      total++; if (err !== 1'b0) $display("FAIL sim0_err: got %b want 0", err); else passed++;
      wb_valid = 1; wb_dsel = 5'd9;
      tick();
      idle(); #1;
      total++; if (busy_mask !== 32'h0) $display("FAIL sim0_drain: got %h want 0", busy_mask); else passed++;
      total++; if (err !== 1'b0) $display("FAIL sim0_drain_err: got %b want 0", err); else passed++;
      tick();
   endtask

   task automatic test_flush_err();
      idle(); issue_valid = 1; issue_wen = 1;
      issue_dsel = 5'd1; tick();
      issue_dsel = 5'd2; tick();
      issue_dsel = 5'd3; tick();
      idle(); #1;
      total++; if (busy_mask !== 32'hE) $display("FAIL fl_pre_busy: got %h want 0000000e", busy_mask); else passed++;
      flush = 1; issue_valid = 1; issue_wen = 1; issue_dsel = 5'd4;
      wb_valid = 1; wb_dsel = 5'd10;
      tick();
      idle(); #1;
      total++; if (busy_mask !== 32'h0) $display("FAIL fl_busy: got %h want 0", busy_mask); else passed++;
      total++; if (err !== 1'b0) $display("FAIL fl_err: got %b want 0", err); else passed++;
      wb_valid = 1; wb_dsel = 5'd4;
      tick();
      idle(); #1;
      total++; if (err !== 1'b1) $display("FAIL err_set: got %b want 1", err); else passed++;
      total++; if (busy_mask !== 32'h0) $display("FAIL err_busy: got %h want 0", busy_mask); else passed++;
      tick(); tick(); #1;
      total++; if (err !== 1'b1) $display("FAIL err_sticky: got %b want 1", err); else passed++;
   endtask

   task automatic test_reset_mid();
      idle(); issue_valid = 1; issue_wen = 1; issue_dsel = 5'd12;
      tick();
      issue_wen = 0; issue_asel = 5'd12; #1;
      total++; if (stall !== 1'b1) $display("FAIL mid_pre_stall: got %b want 1", stall); else passed++;
      #1 reset_n = 0; #1;
      total++; if (busy_mask !== 32'h0) $display("FAIL mid_busy: got %h want 0", busy_mask); else passed++;
      total++; if (err !== 1'b0) $display("FAIL mid_err: got %b want 0", err); else passed++;
      total++; if (stall !== 1'b0) $display("FAIL mid_stall: got %b want 0", stall); else passed++;
      total++; if (hazard_a !== 1'b0) $display("FAIL mid_hz_a: got %b want 0", hazard_a); else passed++;
      @(negedge clk); reset_n = 1; idle();
      tick();
   endtask

   initial begin
      reset_n = 0;
      idle();
      test_reset();
      test_raw();
      test_zero();
      test_sat();
      test_simul();
      test_flush_err();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
